// File: rtl/window_fetch_ctrl_if.sv
// Handshake bundle between the window fetch controller, pixel memory,
// 3x3 window buffer and Sobel stage.
interface window_fetch_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              mem_rvalid;
    logic              start_shift;
    logic [1:0]        shift_direc;
    logic              shift_done;
    logic              start_read;
    logic [7:0]        data_r;
    logic [3:0]        read_idx;
    logic              read_done;
    logic              win_valid;
    logic              win_ack;
    logic              busy;
    logic              frame_done;

    modport master (
        input  start, mem_rdata, mem_rvalid, shift_done, read_done, win_ack,
        output mem_ren, mem_addr, start_shift, shift_direc, start_read,
               data_r, read_idx, win_valid, busy, frame_done
    );

    modport slave (
        output start, mem_rdata, mem_rvalid, shift_done, read_done, win_ack,
        input  mem_ren, mem_addr, start_shift, shift_direc, start_read,
               data_r, read_idx, win_valid, busy, frame_done
    );
endinterface

// File: rtl/window_fetch_ctrl.sv
// Scans 3x3 window centres over a frame in snake order, fetching only the
// pixels that enter the window on each move and handing them to the buffer.
module window_fetch_ctrl #(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 16
) (
    input  logic           clk,
    input  logic           n_rst,
    window_fetch_if.master bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [3:0] {
        IDLE, LOAD_REQ, LOAD_WAIT, BUF_WR, BUF_WAIT,
        WIN_OUT, SHIFT, SHIFT_WAIT, DONE
    } state_t;

    typedef enum logic [1:0] {L_FULL, L_RIGHT, L_LEFT, L_DOWN} list_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cx_reg, cx_next;
    logic [RW-1:0]     cy_reg, cy_next;
    logic [1:0]        wr_reg, wr_next;   // window row offset of current list entry
    logic [1:0]        wc_reg, wc_next;   // window column offset of current list entry
    list_t             mode_reg, mode_next;

    logic              mem_ren_reg, start_shift_reg, start_read_reg;
    logic              win_valid_reg, busy_reg, frame_done_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [1:0]        shift_direc_reg;
    logic [7:0]        data_r_reg;
    logic [3:0]        read_idx_reg;

    logic              row_end, last_pos, list_last;
    logic [1:0]        dir_pick;
    logic [3:0]        slot_idx;
    logic [ADDR_W-1:0] pix_row, pix_col, pix_addr;

    // Odd rows travel right, even rows travel left; the row ends at the far edge.
    assign row_end   = cy_reg[0] ? (cx_reg == CW'(IMG_W - 2)) : (cx_reg == CW'(1));
    assign last_pos  = row_end && (cy_reg == RW'(IMG_H - 2));
    assign list_last = (wr_reg == 2'd2) && (wc_reg == ((mode_reg == L_LEFT) ? 2'd0 : 2'd2));
    assign dir_pick  = row_end ? DIR_DOWN : (cy_reg[0] ? DIR_RIGHT : DIR_LEFT);
    assign slot_idx  = 4'(wr_reg) * 4'd3 + 4'(wc_reg);

    always_comb begin
        state_next = state_reg;
        cx_next    = cx_reg;
        cy_next    = cy_reg;
        wr_next    = wr_reg;
        wc_next    = wc_reg;
        mode_next  = mode_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    cx_next    = CW'(1);
                    cy_next    = RW'(1);
                    wr_next    = 2'd0;
                    wc_next    = 2'd0;
                    mode_next  = L_FULL;
                    state_next = LOAD_REQ;
                end
            end
            LOAD_REQ:  state_next = LOAD_WAIT;
            LOAD_WAIT: if (bus.mem_rvalid) state_next = BUF_WR;
            BUF_WR:    state_next = BUF_WAIT;
            BUF_WAIT: begin
                if (bus.read_done) begin
                    if (list_last) begin
                        state_next = WIN_OUT;
                    end else begin
                        state_next = LOAD_REQ;
                        case (mode_reg)
                            L_FULL: begin
                                if (wc_reg == 2'd2) begin
                                    wc_next = 2'd0;
                                    wr_next = wr_reg + 2'd1;
                                end else begin
                                    wc_next = wc_reg + 2'd1;
                                end
                            end
                            L_DOWN:  wc_next = wc_reg + 2'd1;
                            default: wr_next = wr_reg + 2'd1;
                        endcase
                    end
                end
            end
            WIN_OUT: if (bus.win_ack) state_next = last_pos ? DONE : SHIFT;
            SHIFT:   state_next = SHIFT_WAIT;
            SHIFT_WAIT: begin
                if (bus.shift_done) begin
                    state_next = LOAD_REQ;
                    case (shift_direc_reg)
                        DIR_RIGHT: begin
                            cx_next   = cx_reg + CW'(1);
                            mode_next = L_RIGHT;
                            wr_next   = 2'd0;
                            wc_next   = 2'd2;
                        end
                        DIR_LEFT: begin
                            cx_next   = cx_reg - CW'(1);
                            mode_next = L_LEFT;
                            wr_next   = 2'd0;
                            wc_next   = 2'd0;
                        end
                        default: begin
                            cy_next   = cy_reg + RW'(1);
                            mode_next = L_DOWN;
                            wr_next   = 2'd2;
                            wc_next   = 2'd0;
                        end
                    endcase
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address of the entry about to be requested, from the post-transition position.
    always_comb begin
        pix_row  = ADDR_W'(32'(cy_next) + 32'(wr_next) - 32'd1);
        pix_col  = ADDR_W'(32'(cx_next) + 32'(wc_next) - 32'd1);
        pix_addr = pix_row * ADDR_W'(IMG_W) + pix_col;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
            cx_reg    <= '0;
            cy_reg    <= '0;
            wr_reg    <= '0;
            wc_reg    <= '0;
            mode_reg  <= L_FULL;
        end else begin
            state_reg <= state_next;
            cx_reg    <= cx_next;
            cy_reg    <= cy_next;
            wr_reg    <= wr_next;
            wc_reg    <= wc_next;
            mode_reg  <= mode_next;
        end
    end

    // Outputs are decoded from the next state so every pulse lines up with its state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem_ren_reg     <= 1'b0;
            mem_addr_reg    <= '0;
            start_shift_reg <= 1'b0;
            shift_direc_reg <= 2'b00;
            start_read_reg  <= 1'b0;
            data_r_reg      <= 8'h00;
            read_idx_reg    <= 4'd0;
            win_valid_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            frame_done_reg  <= 1'b0;
        end else begin
            mem_ren_reg     <= (state_next == LOAD_REQ);
            start_read_reg  <= (state_next == BUF_WR);
            start_shift_reg <= (state_next == SHIFT);
            win_valid_reg   <= (state_next == WIN_OUT);
            frame_done_reg  <= (state_next == DONE);
            busy_reg        <= (state_next != IDLE) && (state_next != DONE);
            if (state_next == LOAD_REQ)
                mem_addr_reg <= pix_addr;
            if (state_reg == LOAD_WAIT && bus.mem_rvalid)
                data_r_reg <= bus.mem_rdata;
            if (state_next == BUF_WR)
                read_idx_reg <= slot_idx;
            if (state_reg == WIN_OUT && state_next == SHIFT)
                shift_direc_reg <= dir_pick;
        end
    end

    assign bus.mem_ren     = mem_ren_reg;
    assign bus.mem_addr    = mem_addr_reg;
    assign bus.start_shift = start_shift_reg;
    assign bus.shift_direc = shift_direc_reg;
    assign bus.start_read  = start_read_reg;
    assign bus.data_r      = data_r_reg;
    assign bus.read_idx    = read_idx_reg;
    assign bus.win_valid   = win_valid_reg;
    assign bus.busy        = busy_reg;
    assign bus.frame_done  = frame_done_reg;
endmodule

// File: doc/window_fetch_ctrl.md
WINDOW_FETCH_CTRL -- requirements
Module: window_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 16: image width in pixels, minimum 3.
REQ-002 The block SHALL have parameter IMG_H, default 16: image height in pixels, minimum 3.
REQ-003 The block SHALL have parameter ADDR_W, default 16: pixel address width.
REQ-004 The block SHALL have these ports:
 clk  in  1  system clock; all state changes on rising edge.
 n_rst  in  1  asynchronous, active-low reset.
 start  in  1  pulse that begins one frame scan.
 mem_ren  out  1  one-cycle pixel read request.
 mem_addr  out  ADDR_W  pixel address, valid while mem_ren=1.
 mem_rdata  in  8  pixel from memory.
 mem_rvalid  in  1  mem_rdata valid; latency of 1 or more cycles after mem_ren.
 start_shift  out  1  one-cycle pulse to the window buffer.
 shift_direc  out  2  01 = move right, 10 = move left, 11 = move down; held until shift_done.
 shift_done  in  1  window buffer finished the shift.
 start_read  out  1  one-cycle pulse: load data_r into window slot read_idx.
 data_r  out  8  pixel for the window buffer, held until read_done.
 read_idx  out  4  target slot 0..8, raster order within the 3x3 window.
 read_done  in  1  window buffer stored data_r.
 win_valid  out  1  full 3x3 window ready for the Sobel stage; held until win_ack.
 win_ack  in  1  Sobel stage consumed the window.
 busy  out  1  high from accepted start until frame_done.
 frame_done  out  1  one-cycle pulse after the last window is acknowledged.

Function
REQ-005 Window centres (cx,cy) SHALL span 1..IMG_W-2 by 1..IMG_H-2 in snake order: rows with odd cy run left to right, rows with even cy run right to left, with a move down at each row end.
REQ-006 Pixel address SHALL be row*IMG_W+col, truncated to ADDR_W bits.
REQ-007 The FSM states SHALL be IDLE, LOAD_REQ, LOAD_WAIT, BUF_WR, BUF_WAIT, WIN_OUT, SHIFT, SHIFT_WAIT and DONE.
REQ-008 In IDLE, start=1 SHALL set cx=1, cy=1, busy=1 and enter LOAD_REQ with a 9-pixel fetch list (slots 0..8, raster order).
REQ-009 In LOAD_REQ, mem_ren SHALL pulse for one cycle with the address of the current list entry, then the FSM SHALL enter LOAD_WAIT.
REQ-010 In LOAD_WAIT, the block SHALL capture mem_rdata into data_r on mem_rvalid and enter BUF_WR.
REQ-011 In BUF_WR, start_read SHALL pulse for one cycle with read_idx set to the slot, then the FSM SHALL enter BUF_WAIT.
REQ-012 In BUF_WAIT, on read_done the block SHALL advance the list: if more entries remain it SHALL return to LOAD_REQ, otherwise it SHALL enter WIN_OUT.
REQ-013 In WIN_OUT, win_valid SHALL be 1; on win_ack the block SHALL enter DONE at the last position, otherwise SHALL enter SHIFT.
REQ-014 On entering SHIFT, shift_direc SHALL be chosen from scan position: at a row end it SHALL be 11, otherwise 01 on odd rows and 10 on even rows.
REQ-015 SHIFT SHALL pulse start_shift for one cycle; SHIFT_WAIT SHALL update cx/cy on shift_done and load a 3-pixel list.
REQ-016 The 3-pixel list SHALL use slots 2,5,8 at column cx+1 for a right move; slots 0,3,6 at column cx-1 for a left move; slots 6,7,8 at row cy+1 for a down move.
REQ-017 In DONE, frame_done SHALL pulse for one cycle, busy SHALL fall, and the FSM SHALL return to IDLE.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 mem_rvalid, read_done, shift_done and win_ack received outside their wait states SHALL be ignored.
REQ-020 At most one mem_ren SHALL be outstanding at any time.
REQ-021 start_read, start_shift and mem_ren SHALL never be high in the same cycle.
REQ-022 Every output SHALL be registered.

Reset
REQ-023 n_rst=0 SHALL force IDLE immediately, at any state including mid-frame.
REQ-024 Reset SHALL set all outputs to 0: mem_ren, mem_addr, start_shift, shift_direc, start_read, data_r, read_idx, win_valid, busy and frame_done.
REQ-025 After reset release, a new start SHALL be required, and no earlier request SHALL be resumed.

Verification
REQ-026 With IMG_W=4 and IMG_H=4, a start SHALL produce first-load addresses 0,1,2,4,5,6,8,9,10 to slots 0..8, then win_valid.
REQ-027 With IMG_W=4 and IMG_H=4, after the first win_ack the bench SHALL see shift_direc=01, then addresses 3,7,11 to slots 2,5,8.
REQ-028 The same scan SHALL continue with a down move (11, addresses 13,14,15 to slots 6,7,8), then a left move (10, addresses 4,8,12 to slots 0,3,6), then frame_done after the 4th win_ack, for 18 reads in total.
REQ-029 Stretching mem_rvalid latency to 5 cycles and holding read_done, shift_done and win_ack low for 3 cycles SHALL leave the address sequence unchanged and keep outputs stable while stalled.
REQ-030 Spurious win_ack or read_done while in LOAD_WAIT, and start while busy, SHALL produce no state change and no extra mem_ren.
REQ-031 Asserting n_rst=0 during the second BUF_WAIT SHALL zero all outputs at once, and a fresh start SHALL restart from address 0.
